// File: rtl/can_stuff_pkg.sv
// can_stuff_pkg
// Shared definitions for the CAN de-stuffer: FSM state encoding, default
// stuffing parameters and the run-counter width helper.
package can_stuff_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DYN   = 2'd1,
        FIXED = 2'd2,
        ERR   = 2'd3
    } stuff_state_t;

    localparam int STUFF_LEN_DEF = 5;
    localparam int FIXED_LEN_DEF = 4;
    localparam int SCNT_W_DEF    = 3;

    // Bits needed to hold a count of 0..n inclusive.
    function automatic int run_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/stuff_run_counter.sv
// stuff_run_counter
// Saturating bit counter used for the dynamic equal-bit run length and the
// fixed-stuffing data-bit count.
//   clk, reset   : clock, async active-low reset
//   i_clr        : clear the count (to 1 if i_inc is also high, else to 0)
//   i_inc        : count one more bit (saturates at LIMIT)
//   o_at_limit   : count equals LIMIT, i.e. next bit must be a stuff bit
module stuff_run_counter
    import can_stuff_pkg::*;
#(
    parameter int LIMIT = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_at_limit
);
    localparam int W = run_w(LIMIT);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            // clear+inc means "this bit starts a new run of one"
            r_cnt <= i_inc ? W'(1) : '0;
        end else if (i_inc && (r_cnt != W'(LIMIT))) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_at_limit = (r_cnt == W'(LIMIT));

endmodule

// File: rtl/can_destuff_checker.sv
// can_destuff_checker
// CAN bit de-stuffer and stuff-rule checker. Removes dynamic and fixed stuff
// bits from the sampled stream, flags stuff violations and counts removed
// dynamic stuff bits.
//   clk, reset    : clock, async active-low reset
//   sp            : sample-point strobe; rx/f_stf/fixed_mode valid when high
//   rx            : sampled bus bit (0 = dominant)
//   f_stf         : 0 = bit is inside the stuffed region
//   fixed_mode    : 1 = fixed stuffing (CAN FD CRC field)
//   data_out      : de-stuffed bit, qualified by data_valid
//   data_valid    : one-cycle pulse per data bit
//   stuff_pulse   : one-cycle pulse per legal stuff bit dropped
//   stf_err_n     : active-low stuff error level, cleared on region exit
//   dyn_stuff_cnt : dynamic stuff bits removed in this region (wraps)
module can_destuff_checker
    import can_stuff_pkg::*;
#(
    parameter int STUFF_LEN = STUFF_LEN_DEF,
    parameter int FIXED_LEN = FIXED_LEN_DEF,
    parameter int SCNT_W    = SCNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sp,
    input  logic              rx,
    input  logic              f_stf,
    input  logic              fixed_mode,
    output logic              data_out,
    output logic              data_valid,
    output logic              stuff_pulse,
    output logic              stf_err_n,
    output logic [SCNT_W-1:0] dyn_stuff_cnt
);
    stuff_state_t      r_state, w_nxt_state;
    logic              r_prev;
    logic              r_dout, r_dv, r_sp, r_err_n;
    logic [SCNT_W-1:0] r_cnt;

    logic w_diff, w_dv, w_sp, w_err;
    logic w_run_clr, w_run_inc, w_run_lim;
    logic w_fix_clr, w_fix_inc, w_fix_lim;
    logic w_cnt_clr, w_cnt_inc;

    assign w_diff = (rx != r_prev);

    stuff_run_counter #(.LIMIT(STUFF_LEN)) u_run (
        .clk(clk), .reset(reset), .i_clr(w_run_clr), .i_inc(w_run_inc),
        .o_at_limit(w_run_lim)
    );

    stuff_run_counter #(.LIMIT(FIXED_LEN)) u_fix (
        .clk(clk), .reset(reset), .i_clr(w_fix_clr), .i_inc(w_fix_inc),
        .o_at_limit(w_fix_lim)
    );

    always_comb begin
        w_nxt_state = r_state;
        w_dv        = 1'b0;
        w_sp        = 1'b0;
        w_err       = 1'b0;
        w_run_clr   = 1'b0;
        w_run_inc   = 1'b0;
        w_fix_clr   = 1'b0;
        w_fix_inc   = 1'b0;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
        if (sp) begin
            if (f_stf) begin
                w_nxt_state = IDLE;
                w_dv        = 1'b1;
                w_run_clr   = 1'b1;
                w_fix_clr   = 1'b1;
            end else begin
                case (r_state)
                    IDLE, DYN: begin
                        if (r_state == IDLE) w_cnt_clr = 1'b1;
                        if (fixed_mode) begin
                            // entering fixed stuffing: this bit is the first fixed stuff bit
                            w_fix_clr = 1'b1;
                            if (w_diff) begin
                                w_nxt_state = FIXED;
                                w_sp        = 1'b1;
                            end else begin
                                w_nxt_state = ERR;
                                w_err       = 1'b1;
                            end
                        end else if (r_state == IDLE) begin
                            w_nxt_state = DYN;
                            w_dv        = 1'b1;
                            w_run_clr   = 1'b1;
                            w_run_inc   = 1'b1;
                        end else if (w_run_lim) begin
                            if (w_diff) begin
                                w_sp      = 1'b1;
                                w_cnt_inc = 1'b1;
                                w_run_clr = 1'b1;
                                w_run_inc = 1'b1;
                            end else begin
                                w_nxt_state = ERR;
                                w_err       = 1'b1;
                            end
                        end else begin
                            w_dv      = 1'b1;
                            w_run_inc = 1'b1;
                            w_run_clr = w_diff;
                        end
                    end
                    FIXED: begin
                        if (w_fix_lim) begin
                            if (w_diff) begin
                                w_sp      = 1'b1;
                                w_fix_clr = 1'b1;
                            end else begin
                                w_nxt_state = ERR;
                                w_err       = 1'b1;
                            end
                        end else begin
                            w_dv      = 1'b1;
                            w_fix_inc = 1'b1;
                        end
                    end
                    default: ;  // ERR: hold until region exit or reset
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_nxt_state;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prev  <= 1'b1;
            r_dout  <= 1'b1;
            r_dv    <= 1'b0;
            r_sp    <= 1'b0;
            r_err_n <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_dv <= w_dv;
            r_sp <= w_sp;
            if (sp) begin
                r_prev <= rx;
                r_dout <= rx;
                if (f_stf)      r_err_n <= 1'b1;
                else if (w_err) r_err_n <= 1'b0;
            end
            if (w_cnt_clr)      r_cnt <= '0;
            else if (w_cnt_inc) r_cnt <= r_cnt + 1'b1;
        end
    end

    assign data_out      = r_dout;
    assign data_valid    = r_dv;
    assign stuff_pulse   = r_sp;
    assign stf_err_n     = r_err_n;
    assign dyn_stuff_cnt = r_cnt;

endmodule

// File: doc/can_destuff_checker.md
# can_destuff_checker

Parametrised CAN bit de-stuffer and stuff-rule checker, sitting between the bit-timing logic (sample-point strobe) and the frame decoder. It supports dynamic stuffing (classic CAN and CAN FD arbitration/data fields) and fixed stuffing (CAN FD CRC field). Stuff bits are removed from the output stream, and each violation raises the active-low `stf_err_n`. It also counts removed dynamic stuff bits for the CAN FD stuff-count field.

## Interface
- `STUFF_LEN`, 5: run length of equal bits after which a dynamic stuff bit is mandatory (legal 2..15).
- `FIXED_LEN`, 4: data bits between fixed stuff bits (legal 2..15).
- `SCNT_W`, 3: width of the dynamic stuff counter; wraps modulo 2^SCNT_W.
- `clk`  in  1  system clock; all state changes on posedge.
- `reset`  in  1  asynchronous, active-low reset.
- `sp`  in  1  sample-point strobe, one `clk` cycle wide; `rx`, `f_stf` and `fixed_mode` are sampled only when `sp`=1.
- `rx`  in  1  sampled bus bit (0 dominant).
- `f_stf`  in  1  active-low stuff-area flag; 0 means the current bit lies inside the stuffed region.
- `fixed_mode`  in  1  1 selects fixed stuffing (meaningful only when `f_stf`=0).
- `data_out`  out  1  de-stuffed bit.
- `data_valid`  out  1  one-cycle pulse marking `data_out` as a data bit.
- `stuff_pulse`  out  1  one-cycle pulse: the sampled bit was a legal stuff bit and was dropped.
- `stf_err_n`  out  1  active-low stuff error level.
- `dyn_stuff_cnt`  out  SCNT_W  count of dynamic stuff bits removed since the start of the stuffed region.

## Operation
- The state machine has four states: IDLE, DYN, FIXED and ERR. State changes occur only on `clk` edges where `sp`=1.
- **Region exit has priority.** On any `sp` with `f_stf`=1:
  - the next state is IDLE, whatever the current state;
  - the bit passes through with `data_valid`=1;
  - the run counter is cleared;
  - `stf_err_n` returns to 1.
- **IDLE → DYN or FIXED.** On `sp` with `f_stf`=0, IDLE moves to DYN if `fixed_mode`=0, otherwise to FIXED. In both cases `dyn_stuff_cnt` is cleared.
- **DYN: run tracking.**
  - The first bit in the region is data and starts a run of length 1.
  - Each further bit equal to `prev_bit` increments the run count; a differing bit resets it to 1.
- **DYN: stuff position.** When the run count equals `STUFF_LEN`, the next bit is a stuff bit.
  - If it differs from `prev_bit`, it is legal: `stuff_pulse`=1, `data_valid`=0, `dyn_stuff_cnt` increments, and the stuff bit starts a new run of 1.
  - If it equals `prev_bit`, it is an error: `stf_err_n`=0 and the next state is ERR.
- **DYN → FIXED.** An `sp` in DYN with `fixed_mode`=1 moves to FIXED. That bit is treated as the first fixed stuff bit and must be the inverse of `prev_bit`.
- **FIXED.**
  - A stuff bit is expected at entry and after every `FIXED_LEN` data bits.
  - A legal stuff bit is the inverse of `prev_bit` and produces `stuff_pulse`=1.
  - A stuff bit equal to `prev_bit` is an error: the next state is ERR.
  - `dyn_stuff_cnt` holds its value while in FIXED.
- **ERR.**
  - `stf_err_n` stays 0.
  - `data_valid` and `stuff_pulse` stay 0.
  - Only exit via `f_stf`=1 or reset.
- `prev_bit` updates on every `sp`, whether the bit was stuff or data.

## Timing
- Outputs are registered; each output updates on the `clk` edge at which `sp`=1, so it is visible one cycle after the strobe.
- `data_valid` and `stuff_pulse`:
  - are high for exactly one cycle per `sp`;
  - are mutually exclusive;
  - are both 0 when `sp`=0.
- Reset values: state IDLE, `data_out`=1, `data_valid`=0, `stuff_pulse`=0, `stf_err_n`=1, `dyn_stuff_cnt`=0, `prev_bit`=1, run count 0.
- Reset in mid-region takes effect immediately. The first `sp` after reset is handled as from IDLE.
- `dyn_stuff_cnt` wraps from 2^SCNT_W−1 to 0 without a flag.
- Back-to-back `sp` on consecutive cycles must be supported.

## Structure
- Shared package `can_stuff_pkg`:
  - state enum `stuff_state_t` (IDLE, DYN, FIXED, ERR);
  - default constants for `STUFF_LEN`, `FIXED_LEN` and `SCNT_W`;
  - function `run_w(n)` = $clog2(n+1).
- One sub-module, `stuff_run_counter`, implements the saturating equal-bit counter with a clear input and a compare-to-`LIMIT` output. It is instantiated twice: once for the DYN run count and once for the FIXED data-bit count.

## Test plan
- **Legal dynamic stuff:** reset, then `f_stf`=0 and rx 0,0,0,0,0,1(stuff),0. Expect 5 `data_valid` pulses, then 1 `stuff_pulse`, then `data_valid` with `data_out`=0, `dyn_stuff_cnt`=1, and `stf_err_n` held at 1.
- **Dynamic stuff error:** rx 1×5 then a 6th 1. Expect `stf_err_n`=0 one cycle after the 6th `sp` and no further pulses; raising `f_stf`=1 restores `stf_err_n`=1.
- **Stuff bit starts a new run:** rx 0×5, 1(stuff), 1,1,1,1, then 0. Expect the 0 to be accepted as a stuff bit, with `dyn_stuff_cnt`=2.
- **Fixed mode:** DYN ends with `prev_bit`=1, then `fixed_mode`=1 and rx 0(stuff), d,d,d,d, stuff=~d.
  - Expect `stuff_pulse` at positions 1 and 6.
  - Driving the second stuff bit equal to `prev_bit` instead must give `stf_err_n`=0.
- **Counter wrap:** 9 legal dynamic stuff bits with `SCNT_W`=3. Expect `dyn_stuff_cnt`=1.
- **Reset mid-region:** assert `reset`=0 after 3 equal bits in DYN, release, then send 3 more equal bits. Expect no stuff expected and no error, since the run restarted.
